// File: rtl/status_led_sequencer_pkg.sv
// Shared FSM state type and LED frame constants for the status LED sequencer.
package status_led_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      CHID,
      SCAN,
      SHOW
   } state_t;

   // Header frame is every LED lit; the channel-ID frame carries this two-bit prefix.
   localparam logic       HDR_LEVEL   = 1'b1;
   localparam logic [1:0] CHID_PREFIX = 2'b10;

endpackage

// File: rtl/status_led_sequencer_if.sv
// Bundle between the status sources / LED mux and the status LED sequencer.
interface status_led_sequencer_if #(
   parameter int NCH = 2,
   parameter int SW  = 97,
   parameter int LW  = 8
);
   import status_led_pkg::*;

   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0]    asserted_i;
   logic [NCH*SW-1:0] status_i;
   logic              ack_i;
   logic              led_drive_o;
   logic [LW-1:0]     led_data_o;
   logic              busy_o;
   logic [CW-1:0]     chan_o;

   modport master (
      output asserted_i, status_i, ack_i,
      input  led_drive_o, led_data_o, busy_o, chan_o
   );

   modport slave (
      input  asserted_i, status_i, ack_i,
      output led_drive_o, led_data_o, busy_o, chan_o
   );

endinterface

// File: rtl/status_led_sequencer_dwell_timer.sv
// Down-counting frame timer; start_i reloads it and done_o pulses once when it reaches zero.
module led_dwell_timer #(
   parameter int DWELL_CYC = 100_000_000
) (
   input  logic clk,
   input  logic resetn,
   input  logic start_i,
   output logic done_o
);

   localparam int            DW   = $clog2(DWELL_CYC);
   localparam logic [DW-1:0] LOAD = DW'(DWELL_CYC - 1);

   logic [DW-1:0] cnt;
   logic          run;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt <= '0;
         run <= 1'b0;
      end else if (start_i) begin
         cnt <= LOAD;
         run <= 1'b1;
      end else if (run) begin
         if (cnt == '0) begin
            run <= 1'b0;
         end else begin
            cnt <= cnt - DW'(1);
         end
      end
   end

   assign done_o = run && (cnt == '0);

endmodule

// File: rtl/status_led_sequencer.sv
// Round-robin alarm display: header, channel ID, then each set status bit index on the LEDs.
// Optional idle heartbeat on the LED MSB when STATUS_LED_HEARTBEAT_EN is defined.
module status_led_sequencer
   import status_led_pkg::*;
#(
   parameter int NCH       = 2,
   parameter int SW        = 97,
   parameter int LW        = 8,
   parameter int DWELL_CYC = 100_000_000
) (
   input  logic                  clk,
   input  logic                  resetn,
   status_led_sequencer_if.slave bus
);

   localparam int            CW       = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int            BW       = (SW > 1) ? $clog2(SW) : 1;
   localparam logic [BW-1:0] LAST_IDX = BW'(SW - 1);

   state_t          state, state_n;
   logic [NCH-1:0]  asserted_q, rise, pending, pending_n, pending_clr;
   logic [CW-1:0]   rr_ptr, rr_ptr_n, chan, chan_n, pick;
   logic            pick_ok;
   logic [SW-1:0]   sr, sr_n;
   logic [BW-1:0]   bit_idx, bit_idx_n;
   logic [LW-1:0]   led_data, led_data_n;
   logic            led_drive, led_drive_n;
   logic            dwell_start, dwell_done, go_idle;
`ifdef STATUS_LED_HEARTBEAT_EN
   logic            hb_armed, hb_armed_n;
`endif

   // Rotate the request vector so the search starts at ptr; lowest offset wins.
   function automatic logic [CW:0] rr_pick(input logic [NCH-1:0] req, input logic [CW-1:0] ptr);
      logic [2*NCH-1:0] rot;
      logic [CW:0]      res;
      int               c;
      rot = {req, req} >> ptr;
      res = '0;
      c   = 0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (rot[i]) begin
            c = int'(ptr) + i;
            if (c >= NCH) c = c - NCH;
            res = {1'b1, CW'(c)};
         end
      end
      return res;
   endfunction

   led_dwell_timer #(.DWELL_CYC(DWELL_CYC)) u_dwell (
      .clk     (clk),
      .resetn  (resetn),
      .start_i (dwell_start),
      .done_o  (dwell_done)
   );

   assign rise             = bus.asserted_i & ~asserted_q;
   assign {pick_ok, pick}  = rr_pick(pending, rr_ptr);

   always_comb begin
      state_n     = state;
      rr_ptr_n    = rr_ptr;
      chan_n      = chan;
      sr_n        = sr;
      bit_idx_n   = bit_idx;
      led_data_n  = led_data;
      led_drive_n = led_drive;
      pending_clr = '0;
      dwell_start = 1'b0;
      go_idle     = 1'b0;
`ifdef STATUS_LED_HEARTBEAT_EN
      hb_armed_n  = hb_armed;
`endif
      unique case (state)
         IDLE: begin
            if (pick_ok) begin
               sr_n        = SW'(bus.status_i >> (int'(pick) * SW));
               pending_clr = NCH'(1) << pick;
               chan_n      = pick;
               rr_ptr_n    = (int'(pick) == NCH - 1) ? '0 : pick + CW'(1);
               led_drive_n = 1'b1;
               led_data_n  = {LW{HDR_LEVEL}};
               dwell_start = 1'b1;
               state_n     = HDR;
`ifdef STATUS_LED_HEARTBEAT_EN
               hb_armed_n  = 1'b0;
            end else if (!hb_armed) begin
               led_drive_n = 1'b1;
               led_data_n  = '0;
               dwell_start = 1'b1;
               hb_armed_n  = 1'b1;
            end else if (dwell_done) begin
               led_data_n[LW-1] = ~led_data[LW-1];
               dwell_start      = 1'b1;
`endif
            end
         end
         HDR: begin
            if (dwell_done) begin
               led_data_n  = {CHID_PREFIX, (LW-2)'(chan)};
               dwell_start = 1'b1;
               state_n     = CHID;
            end
         end
         CHID: begin
            if (dwell_done) begin
               bit_idx_n = '0;
               state_n   = SCAN;
            end
         end
         SCAN: begin
            // One status bit per clock; sr[0] always lines up with bit_idx.
            if (sr[0]) begin
               led_data_n  = LW'(bit_idx);
               dwell_start = 1'b1;
               state_n     = SHOW;
            end else if (bit_idx == LAST_IDX) begin
               go_idle = 1'b1;
            end else begin
               sr_n      = sr >> 1;
               bit_idx_n = bit_idx + BW'(1);
            end
         end
         SHOW: begin
            if (dwell_done) begin
               if (bit_idx != LAST_IDX) begin
                  sr_n      = sr >> 1;
                  bit_idx_n = bit_idx + BW'(1);
                  state_n   = SCAN;
               end else begin
                  go_idle = 1'b1;
               end
            end
         end
         default: go_idle = 1'b1;
      endcase

      // Completion and ack both land in IDLE with the idle LED values; ack keeps rr_ptr.
      if (go_idle || bus.ack_i) begin
         state_n     = IDLE;
         chan_n      = '0;
         rr_ptr_n    = rr_ptr;
         led_data_n  = '0;
`ifdef STATUS_LED_HEARTBEAT_EN
         led_drive_n = 1'b1;
         dwell_start = 1'b1;
         hb_armed_n  = 1'b1;
`else
         led_drive_n = 1'b0;
`endif
      end

      pending_n = bus.ack_i ? '0 : ((pending & ~pending_clr) | rise);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         asserted_q <= '0;
         pending    <= '0;
         rr_ptr     <= '0;
         chan       <= '0;
         led_data   <= '0;
         led_drive  <= 1'b0;
`ifdef STATUS_LED_HEARTBEAT_EN
         hb_armed   <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         asserted_q <= bus.asserted_i;
         pending    <= pending_n;
         rr_ptr     <= rr_ptr_n;
         chan       <= chan_n;
         led_data   <= led_data_n;
         led_drive  <= led_drive_n;
`ifdef STATUS_LED_HEARTBEAT_EN
         hb_armed   <= hb_armed_n;
`endif
      end
   end

   // Scan shift register and bit index are reloaded before use, so they need no reset.
   always_ff @(posedge clk) begin
      sr      <= sr_n;
      bit_idx <= bit_idx_n;
   end

   assign bus.led_drive_o = led_drive;
   assign bus.led_data_o  = led_data;
   assign bus.busy_o      = (state != IDLE);
   assign bus.chan_o      = chan;

endmodule

// File: tb/tb_status_led_sequencer.sv
// Directed bench for status_led_sequencer (NCH=2, SW=97, LW=8, DWELL_CYC=4).
module tb_status_led_sequencer;

   localparam int NCH = 2;
   localparam int SW  = 97;
   localparam int LW  = 8;
   localparam int DWC = 4;

`ifdef STATUS_LED_HEARTBEAT_EN
   localparam logic HB = 1'b1;
`else
   localparam logic HB = 1'b0;
`endif

   // Expected frame runs (value, clocks) while busy; frames before a SCAN include its scan clocks.
   // ch0 bits {0,5,96}: FF 4 | 80 4+1 | 00 4+5 | 05 4+91 | 60 4
   // ch1 all zero:      FF 4 | 81 4+97
   localparam int SEQ0_VAL [5] = '{'hFF, 'h80, 'h00, 'h05, 'h60};
   localparam int SEQ0_LEN [5] = '{4, 5, 9, 95, 4};
   localparam int SEQ1_VAL [5] = '{'hFF, 'h81, 0, 0, 0};
   localparam int SEQ1_LEN [5] = '{4, 101, 0, 0, 0};

   logic clk = 1'b0;
   logic resetn;

   status_led_sequencer_if #(.NCH(NCH), .SW(SW), .LW(LW)) bus ();

   status_led_sequencer #(.NCH(NCH), .SW(SW), .LW(LW), .DWELL_CYC(DWC)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int run_val [16];
   int run_len [16];
   int n_runs;
   int chan_bad;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic collect(input string tag, input int exp_chan);
      int k;
      n_runs   = 0;
      chan_bad = 0;
      k        = 0;
      while (bus.busy_o && k < 400) begin
         if (n_runs > 0 && run_val[n_runs-1] == int'(bus.led_data_o)) begin
            run_len[n_runs-1]++;
         end else if (n_runs < 16) begin
            run_val[n_runs] = int'(bus.led_data_o);
            run_len[n_runs] = 1;
            n_runs++;
         end
         if (int'(bus.chan_o) != exp_chan || !bus.led_drive_o) chan_bad++;
         step();
         k++;
      end
      chk({tag, "_ends"}, 32'(k < 400), 32'd1);
      chk({tag, "_chan_drive"}, chan_bad, 0);
   endtask

   task automatic cmp_seq(input string tag, input int which);
      int ne;
      ne = (which == 0) ? 5 : 2;
      chk({tag, "_nframes"}, n_runs, ne);
      for (int i = 0; i < ne && i < n_runs; i++) begin
         chk($sformatf("%s_val%0d", tag, i), run_val[i], (which == 0) ? SEQ0_VAL[i] : SEQ1_VAL[i]);
         chk($sformatf("%s_len%0d", tag, i), run_len[i], (which == 0) ? SEQ0_LEN[i] : SEQ1_LEN[i]);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"},  bus.busy_o,      1'b0);
      chk({tag, "_drive"}, bus.led_drive_o, HB);
      chk({tag, "_data"},  bus.led_data_o,  8'h00);
      chk({tag, "_chan"},  bus.chan_o,      1'b0);
   endtask

   task automatic drop_all();
      bus.asserted_i = '0;
      step();
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int seen;
      resetn         = 1'b0;
      bus.asserted_i = '0;
      bus.status_i   = '0;
      bus.ack_i      = 1'b0;
      repeat (3) step();
      chk("rst_drive", bus.led_drive_o, 1'b0);
      chk("rst_data",  bus.led_data_o,  8'h00);
      chk("rst_busy",  bus.busy_o,      1'b0);
      chk("rst_chan",  bus.chan_o,      1'b0);
      resetn = 1'b1;
      step();

      // 1: ch0 bits {0,5,96}
      bus.status_i[0]  = 1'b1;
      bus.status_i[5]  = 1'b1;
      bus.status_i[96] = 1'b1;
      bus.asserted_i   = 2'b01;
      step();
      chk("t1_lat_busy", bus.busy_o, 1'b0);
      step();
      chk("t1_lat_drive", bus.led_drive_o, 1'b1);
      chk("t1_lat_data",  bus.led_data_o,  8'hFF);
      collect("t1", 0);
      cmp_seq("t1", 0);
      chk_idle("t1_end");

      // 2: ch1 all-zero status
      drop_all();
      bus.asserted_i = 2'b10;
      step();
      step();
      chk("t2_data", bus.led_data_o, 8'hFF);
      chk("t2_chan", bus.chan_o, 1'b1);
      collect("t2", 1);
      cmp_seq("t2", 1);
      chk_idle("t2_end");

      // 3: both rise together with rr_ptr back at 0
      drop_all();
      bus.asserted_i = 2'b11;
      step();
      step();
      collect("t3a", 0);
      cmp_seq("t3a", 0);
      chk("t3_gap_data", bus.led_data_o, 8'h00);
      step();
      chk("t3b_busy", bus.busy_o, 1'b1);
      chk("t3b_chan", bus.chan_o, 1'b1);
      collect("t3b", 1);
      cmp_seq("t3b", 1);
      chk_idle("t3_end");

      // 4: ack while ch0 shows 05 and ch1 is pending; ch0 first proves rr_ptr returned to 0
      drop_all();
      bus.asserted_i = 2'b11;
      k = 0;
      while (bus.led_data_o != 8'h05 && k < 200) begin
         step();
         k++;
      end
      chk("t4_reach05", 32'(k < 200), 32'd1);
      chk("t4_chan0", bus.chan_o, 1'b0);
      bus.ack_i = 1'b1;
      step();
      bus.ack_i = 1'b0;
      chk_idle("t4_ack");
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (bus.busy_o) seen++;
      end
      chk("t4_no_ch1", seen, 0);

      // 5: reset pulse during HDR with asserted_i[0] held high
      drop_all();
      bus.asserted_i = 2'b01;
      step();
      step();
      chk("t5_hdr", bus.led_data_o, 8'hFF);
      step();
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      chk("t5_rst_drive", bus.led_drive_o, 1'b0);
      chk("t5_rst_data",  bus.led_data_o,  8'h00);
      chk("t5_rst_busy",  bus.busy_o,      1'b0);
      chk("t5_rst_chan",  bus.chan_o,      1'b0);
      step();
      chk("t5_r1_busy", bus.busy_o, 1'b0);
      step();
      chk("t5_r2_busy", bus.busy_o, 1'b1);
      chk("t5_r2_data", bus.led_data_o, 8'hFF);
      collect("t5", 0);
      cmp_seq("t5", 0);

      // 6: idle LEDs from IDLE entry (heartbeat toggles MSB every DWC clocks when enabled)
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("t6_drive%0d", i), bus.led_drive_o, HB);
         chk($sformatf("t6_data%0d", i), bus.led_data_o,
             (HB && ((i / DWC) % 2 == 1)) ? 8'h80 : 8'h00);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
